// File: rtl/mantissa_square_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mantissa_square_seq
//  Purpose  : Sequential significand squarer. Computes the exact
//             BINARY_SIZE-bit square of a HALF_BINARY_SIZE-bit significand
//             (hidden bit included) using a shift-add datapath with a
//             start/busy/done handshake. norm_hi flags a square >= 2.0.
//  Options  : SQUARE_MANTISSA_RADIX4_EN - when defined, retires two
//             multiplier bits per cycle (0/1x/2x/3x addend), roughly halving
//             latency. Results are bit-identical in both builds.
//  Revision : 1.0 - initial release
// ============================================================================
module mantissa_square_seq #(
    parameter int HALF_BINARY_SIZE = 53,
    parameter int BINARY_SIZE      = 106
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [HALF_BINARY_SIZE-1:0] op_a,
    output logic                        busy,
    output logic                        done,
    output logic [BINARY_SIZE-1:0]      result,
    output logic                        norm_hi
);

    localparam int CW = $clog2(HALF_BINARY_SIZE + 1);

`ifdef SQUARE_MANTISSA_RADIX4_EN
    // Multiplier padded to an even width so every iteration sees a full digit.
    localparam int             MPW     = HALF_BINARY_SIZE + (HALF_BINARY_SIZE % 2);
    localparam logic [CW-1:0]  c_ITERS = CW'((HALF_BINARY_SIZE + 1) / 2);
`else
    localparam int             MPW     = HALF_BINARY_SIZE;
    localparam logic [CW-1:0]  c_ITERS = CW'(HALF_BINARY_SIZE);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [BINARY_SIZE-1:0] r_mcand;
    logic [MPW-1:0]         r_mplier;
    logic [BINARY_SIZE-1:0] r_acc;
    logic [CW-1:0]          r_cnt;
    logic [BINARY_SIZE-1:0] w_addend;
    logic                   w_busy;
    logic                   w_done;

`ifdef SQUARE_MANTISSA_RADIX4_EN
    // 3x multiple is formed once at accept and then shifted alongside 1x.
    logic [BINARY_SIZE-1:0] r_mcand3;
    logic [BINARY_SIZE-1:0] w_a3;
    assign w_a3 = BINARY_SIZE'(op_a) + (BINARY_SIZE'(op_a) << 1);

    // Select the partial product for the current radix-4 digit.
    always_comb begin
        w_addend = '0;
        case (r_mplier[1:0])
            2'b01:   w_addend = r_mcand;
            2'b10:   w_addend = r_mcand << 1;
            2'b11:   w_addend = r_mcand3;
            default: w_addend = '0;
        endcase
    end
`else
    // Select the partial product for the current multiplier bit.
    always_comb begin
        w_addend = '0;
        if (r_mplier[0]) begin
            w_addend = r_mcand;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = CALC;
                end
            end
            CALC: begin
                w_busy = 1'b1;
                // Counter hits zero on this edge: last iteration.
                if (r_cnt == CW'(1)) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Shift-add datapath: load on accept, accumulate while in CALC,
    // otherwise hold so result stays visible through IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
`ifdef SQUARE_MANTISSA_RADIX4_EN
            r_mcand3 <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mcand  <= BINARY_SIZE'(op_a);
                        r_mplier <= MPW'(op_a);
                        r_acc    <= '0;
                        r_cnt    <= c_ITERS;
`ifdef SQUARE_MANTISSA_RADIX4_EN
                        r_mcand3 <= w_a3;
`endif
                    end
                end
                CALC: begin
                    // Sum cannot exceed (2^H-1)^2 < 2^(2H); truncation of
                    // shifted-out multiplicand bits is harmless mod 2^(2H).
                    r_acc <= r_acc + w_addend;
                    r_cnt <= r_cnt - CW'(1);
`ifdef SQUARE_MANTISSA_RADIX4_EN
                    r_mcand  <= r_mcand << 2;
                    r_mcand3 <= r_mcand3 << 2;
                    r_mplier <= r_mplier >> 2;
`else
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign busy    = w_busy;
    assign done    = w_done;
    assign result  = r_acc;
    assign norm_hi = r_acc[BINARY_SIZE-1];

endmodule
`default_nettype wire

// File: tb/tb_mantissa_square_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mantissa_square_seq
//  Purpose  : Directed self-checking bench for mantissa_square_seq.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mantissa_square_seq;

    localparam int H = 53;
    localparam int B = 106;
`ifdef SQUARE_MANTISSA_RADIX4_EN
    localparam int LAT = 27;   // edges from accept edge to first done sample
`else
    localparam int LAT = 53;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [H-1:0] op_a;
    logic         busy;
    logic         done;
    logic [B-1:0] result;
    logic         norm_hi;

    int n_cmp = 0;
    int n_err = 0;

    mantissa_square_seq #(
        .HALF_BINARY_SIZE (H),
        .BINARY_SIZE      (B)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op_a    (op_a),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .norm_hi (norm_hi)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op_a = '0;
        tick(); tick();
        n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)    begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (result !== '0)    begin n_err++; $display("FAIL reset_result got %h want 0", result); end
        n_cmp++; if (norm_hi !== 1'b0) begin n_err++; $display("FAIL reset_norm got %b want 0", norm_hi); end
        rst = 1'b0;
        tick();
    endtask

    // One full operation: latency, value, flag, single-cycle done, hold in IDLE.
    task automatic run_op(input string nm, input logic [H-1:0] a,
                          input logic [B-1:0] exp_r, input logic exp_n);
        int n;
        start = 1'b1; op_a = a;
        tick();
        start = 1'b0; op_a = ~a;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL %s busy_after_accept got %b want 1", nm, busy); end
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        n_cmp++; if (n != LAT)        begin n_err++; $display("FAIL %s latency got %0d want %0d", nm, n, LAT); end
        n_cmp++; if (result !== exp_r) begin n_err++; $display("FAIL %s result got %h want %h", nm, result, exp_r); end
        n_cmp++; if (norm_hi !== exp_n) begin n_err++; $display("FAIL %s norm_hi got %b want %b", nm, norm_hi, exp_n); end
        tick();
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL %s after_done got done=%b busy=%b want 0 0", nm, done, busy);
        end
        tick();
        n_cmp++; if (result !== exp_r) begin n_err++; $display("FAIL %s result_hold got %h want %h", nm, result, exp_r); end
    endtask

    task automatic test_values();
        run_op("one",   53'h10000000000000, 106'd1 << 104, 1'b0);
        run_op("max",   {H{1'b1}}, {B{1'b1}} - (106'd1 << 54) + 106'd2, 1'b1);
        run_op("one_5", 53'h18000000000000, 106'd9 << 102, 1'b1);
        run_op("zero",  53'h0, 106'd0, 1'b0);
        run_op("one_p", 53'h10000000000001, (106'd1 << 104) + (106'd1 << 53) + 106'd1, 1'b0);
        run_op("three", 53'd3, 106'd9, 1'b0);
    endtask

    // start pulses during CALC and DONE must not launch a second operation.
    task automatic test_ignore_start();
        int dones;
        int n;
        start = 1'b1; op_a = 53'h18000000000000;
        tick();
        start = 1'b0; op_a = 53'h10000000000000;
        dones = 0;
        for (int i = 0; i < 4; i++) tick();
        start = 1'b1; op_a = {H{1'b1}};
        tick();
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 200) begin tick(); n++; end
        if (done === 1'b1) dones++;
        start = 1'b1; op_a = 53'h0;
        tick();
        start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ign_busy_after_done got %b want 0", busy); end
        for (int i = 0; i < 70; i++) begin
            if (done === 1'b1) dones++;
            tick();
        end
        n_cmp++; if (dones != 1) begin n_err++; $display("FAIL ign_done_count got %0d want 1", dones); end
        n_cmp++; if (result !== (106'd9 << 102)) begin
            n_err++; $display("FAIL ign_result got %h want %h", result, 106'd9 << 102);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        start = 1'b1; op_a = {H{1'b1}};
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0 || result !== '0 || done !== 1'b0) begin
            n_err++; $display("FAIL rst_mid got busy=%b done=%b result=%h want 0 0 0", busy, done, result);
        end
        dones = 0;
        for (int i = 0; i < 70; i++) begin
            if (done === 1'b1) dones++;
            tick();
        end
        n_cmp++; if (dones != 0) begin n_err++; $display("FAIL rst_mid_no_done got %0d want 0", dones); end
        // Reset and start together: reset wins.
        rst = 1'b1; start = 1'b1; op_a = 53'd3;
        tick();
        rst = 1'b0; start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_start_busy got %b want 0", busy); end
        run_op("post_rst", 53'h18000000000000, 106'd9 << 102, 1'b1);
    endtask

    // start held high: accepts every LAT+2 edges, each with its own done.
    task automatic test_back_to_back();
        int accepts;
        int dones;
        int first_acc;
        int second_acc;
        logic prev_busy;
        logic prev_done;
        logic dbl;
        logic [B-1:0] exp_r;
        exp_r = (106'd1 << 104) + (106'd1 << 53) + 106'd1;
        accepts = 0; dones = 0; first_acc = -1; second_acc = -1;
        prev_busy = 1'b0; prev_done = 1'b0; dbl = 1'b0;
        start = 1'b1; op_a = 53'h10000000000001;
        for (int e = 1; e <= 2 * (LAT + 2); e++) begin
            tick();
            if (busy === 1'b1 && prev_busy === 1'b0) begin
                accepts++;
                if (first_acc < 0) first_acc = e; else second_acc = e;
            end
            if (done === 1'b1) begin
                dones++;
                if (prev_done === 1'b1) dbl = 1'b1;
                n_cmp++; if (result !== exp_r) begin
                    n_err++; $display("FAIL b2b_result got %h want %h", result, exp_r);
                end
            end
            prev_busy = busy;
            prev_done = done;
        end
        start = 1'b0;
        n_cmp++; if (accepts != 2) begin n_err++; $display("FAIL b2b_accepts got %0d want 2", accepts); end
        n_cmp++; if (dones != 2 || dbl) begin
            n_err++; $display("FAIL b2b_dones got %0d (double=%b) want 2 single", dones, dbl);
        end
        n_cmp++; if (second_acc - first_acc != LAT + 2) begin
            n_err++; $display("FAIL b2b_spacing got %0d want %0d", second_acc - first_acc, LAT + 2);
        end
        tick(); tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op_a = '0;
        test_reset();
        test_values();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
